// File: rtl/error_locations.sv
// Chien search for the RS(204,188) decoder, GF(2^8) with field polynomial 0x11D.
// Evaluates the error locator at alpha^-i, one position per clock, and records
// up to eight root positions in ascending order.
// Optional build macro: RS_SHORTENED_SEARCH_EN limits the sweep to positions 0..203.

// One Chien term: r holds Sigma_K * alpha^(-K*i) for the position being tested.
module error_locations_cell #(
  parameter int K = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] sigma,
  output logic [7:0] r
);

  // Multiply by alpha^-1: shift right and fold bit 0 back in as 0x11D >> 1.
  function automatic logic [7:0] mul_ainv(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'h8E : 8'h00);
  endfunction

  // Multiply by alpha^-K. K is constant, so this flattens to a fixed XOR network.
  function automatic logic [7:0] mul_ainv_k(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int j = 0; j < K; j++) y = mul_ainv(y);
    return y;
  endfunction

  // Load the coefficient once, then step one position per search cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     r <= 8'h00;
    else if (load) r <= sigma;
    else if (en)   r <= mul_ainv_k(r);
  end

endmodule

module error_locations (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Sigma1,
  input  logic [7:0] Sigma2,
  input  logic [7:0] Sigma3,
  input  logic [7:0] Sigma4,
  input  logic [7:0] Sigma5,
  input  logic [7:0] Sigma6,
  input  logic [7:0] Sigma7,
  input  logic [7:0] Sigma8,
  output logic [7:0] Location1,
  output logic [7:0] Location2,
  output logic [7:0] Location3,
  output logic [7:0] Location4,
  output logic [7:0] Location5,
  output logic [7:0] Location6,
  output logic [7:0] Location7,
  output logic [7:0] Location8
);

  localparam int NUM_TERMS = 8;

`ifdef RS_SHORTENED_SEARCH_EN
  localparam logic [7:0] LAST_POS = 8'd203;
`else
  localparam logic [7:0] LAST_POS = 8'd254;
`endif

  typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

  state_t                          st;
  logic [7:0]                      i;
  logic [2:0]                      n;
  logic                            full;
  logic [NUM_TERMS-1:0][7:0]       sigma_v;
  logic [NUM_TERMS-1:0][7:0]       r_v;
  logic [NUM_TERMS-1:0][7:0]       loc;
  logic [7:0]                      s;
  logic                            load_en;
  logic                            search_en;

  assign sigma_v   = {Sigma8, Sigma7, Sigma6, Sigma5, Sigma4, Sigma3, Sigma2, Sigma1};
  assign load_en   = (st == LOAD);
  assign search_en = (st == SEARCH);

  // Term k is seeded with Sigma_k and rotates by alpha^-k each position.
  for (genvar g = 0; g < NUM_TERMS; g++) begin : g_term
    error_locations_cell #(.K(g + 1)) u_cell (
      .Clk   (Clk),
      .Reset (Reset),
      .load  (load_en),
      .en    (search_en),
      .sigma (sigma_v[g]),
      .r     (r_v[g])
    );
  end

  // Lambda(alpha^-i): implicit 1 plus the XOR of all rotating terms.
  always_comb begin
    s = 8'h01;
    for (int k = 0; k < NUM_TERMS; k++) s = s ^ r_v[k];
  end

  // Sequencer: load once, sweep positions, then freeze until the next reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st   <= LOAD;
      i    <= 8'd0;
      n    <= 3'd0;
      full <= 1'b0;
      loc  <= {NUM_TERMS{8'hFF}};
    end else begin
      case (st)
        LOAD: begin
          loc  <= {NUM_TERMS{8'hFF}};
          i    <= 8'd0;
          n    <= 3'd0;
          full <= 1'b0;
          st   <= SEARCH;
        end
        SEARCH: begin
          // Roots beyond the eighth cannot come from a valid locator; drop them.
          if (s == 8'h00 && !full) begin
            loc[n] <= i;
            n      <= n + 3'd1;
            if (n == 3'd7) full <= 1'b1;
          end
          i <= i + 8'd1;
          if (i == LAST_POS) st <= DONE;
        end
        DONE: ;
        default: st <= LOAD;
      endcase
    end
  end

  assign Location1 = loc[0];
  assign Location2 = loc[1];
  assign Location3 = loc[2];
  assign Location4 = loc[3];
  assign Location5 = loc[4];
  assign Location6 = loc[5];
  assign Location7 = loc[6];
  assign Location8 = loc[7];

endmodule

// File: tb/tb_error_locations.sv
// Bench for error_locations: GF(2^8) polynomial evaluation model, checked every cycle.
module tb_error_locations;

`ifdef RS_SHORTENED_SEARCH_EN
  localparam int LAST = 203;
`else
  localparam int LAST = 254;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Sigma1, Sigma2, Sigma3, Sigma4, Sigma5, Sigma6, Sigma7, Sigma8;
  logic [7:0] Location1, Location2, Location3, Location4;
  logic [7:0] Location5, Location6, Location7, Location8;

  int total = 0;
  int bad   = 0;

  logic [7:0] sig [8];
  int         roots [$];

  error_locations dut (
    .Clk(Clk), .Reset(Reset),
    .Sigma1(Sigma1), .Sigma2(Sigma2), .Sigma3(Sigma3), .Sigma4(Sigma4),
    .Sigma5(Sigma5), .Sigma6(Sigma6), .Sigma7(Sigma7), .Sigma8(Sigma8),
    .Location1(Location1), .Location2(Location2), .Location3(Location3), .Location4(Location4),
    .Location5(Location5), .Location6(Location6), .Location7(Location7), .Location8(Location8)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gpow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < e; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Lambda evaluated directly at x = alpha^-pos.
  function automatic logic [7:0] eval_lambda(input int pos);
    logic [7:0] x, xp, acc;
    x = gpow((255 - pos) % 255);
    xp = 8'h01; acc = 8'h01;
    for (int k = 0; k < 8; k++) begin
      xp  = gmul(xp, x);
      acc = acc ^ gmul(sig[k], xp);
    end
    return acc;
  endfunction

  task automatic build_roots();
    roots.delete();
    for (int p = 0; p <= LAST; p++)
      if (eval_lambda(p) == 8'h00 && roots.size() < 8) roots.push_back(p);
  endtask

  // Expected outputs once positions 0..upto have been evaluated (upto<0: none).
  function automatic logic [63:0] exp_upto(input int upto);
    logic [63:0] v;
    v = {8{8'hFF}};
    for (int k = 0; k < roots.size(); k++)
      if (roots[k] <= upto) v[k*8 +: 8] = roots[k][7:0];
    return v;
  endfunction

  function automatic logic [63:0] locs();
    return {Location8, Location7, Location6, Location5, Location4, Location3, Location2, Location1};
  endfunction

  task automatic check(input string tag, input logic [63:0] exp);
    logic [63:0] got;
    got = locs();
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_sigma(input logic [7:0] a [8]);
    Sigma1 = a[0]; Sigma2 = a[1]; Sigma3 = a[2]; Sigma4 = a[3];
    Sigma5 = a[4]; Sigma6 = a[5]; Sigma7 = a[6]; Sigma8 = a[7];
  endtask

  task automatic scramble_sigma();
    logic [7:0] a [8];
    for (int k = 0; k < 8; k++) a[k] = 8'($urandom);
    drive_sigma(a);
  endtask

  task automatic set_sig(input logic [7:0] s1, s2, s3, s4, s5, s6, s7, s8);
    sig[0] = s1; sig[1] = s2; sig[2] = s3; sig[3] = s4;
    sig[4] = s5; sig[5] = s6; sig[6] = s7; sig[7] = s8;
  endtask

  // Lambda = prod (1 + alpha^p x) over cnt distinct random positions in range.
  task automatic random_roots_sig(input int cnt);
    logic [7:0] c [9];
    int         pos [$];
    int         p;
    bit         dup;
    for (int k = 0; k < 9; k++) c[k] = 8'h00;
    c[0] = 8'h01;
    while (pos.size() < cnt) begin
      p = $urandom_range(0, LAST);
      dup = 0;
      foreach (pos[q]) if (pos[q] == p) dup = 1;
      if (!dup) pos.push_back(p);
    end
    foreach (pos[q])
      for (int k = 8; k >= 1; k--) c[k] = c[k] ^ gmul(gpow(pos[q]), c[k-1]);
    for (int k = 0; k < 8; k++) sig[k] = c[k+1];
  endtask

  // Reset, load, sweep and hold; abort_at >= 0 pulses Reset after that position.
  task automatic run(input string tag, input int abort_at);
    build_roots();
    drive_sigma(sig);
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) check({tag, "_rst"}, {8{8'hFF}});
    Reset = 1'b0;
    @(posedge Clk) #1 check({tag, "_load"}, {8{8'hFF}});
    scramble_sigma();
    for (int i = 0; i <= LAST; i++) begin
      @(posedge Clk) #1 check($sformatf("%s_pos%0d", tag, i), exp_upto(i));
      if (i == abort_at) begin
        #2 Reset = 1'b1;
        #1 check({tag, "_async_clr"}, {8{8'hFF}});
        @(posedge Clk) #1 check({tag, "_clr_hold"}, {8{8'hFF}});
        return;
      end
    end
    repeat (4) begin
      @(posedge Clk) #1 check({tag, "_done"}, exp_upto(LAST));
    end
  endtask

  initial begin
    set_sig(0, 0, 0, 0, 0, 0, 0, 0);
    drive_sigma(sig);
    // reset held with arbitrary coefficients
    repeat (5) begin
      scramble_sigma();
      @(posedge Clk) #1 check("reset_hold", {8{8'hFF}});
    end

    set_sig(0, 0, 0, 0, 0, 0, 0, 0);
    run("zero", -1);

    set_sig(8'h20, 0, 0, 0, 0, 0, 0, 0);
    run("alpha5", -1);

    set_sig(8'h06, 8'h08, 0, 0, 0, 0, 0, 0);
    run("pos12", -1);

    set_sig(8'h8E, 0, 0, 0, 0, 0, 0, 0);
    run("pos254", -1);

    set_sig(8'd249, 8'd49, 8'd237, 8'd55, 8'd207, 8'd139, 8'd86, 8'd88);
    run("eight", -1);

    random_roots_sig(8);
    run("abort", 100);
    random_roots_sig(3);
    run("after_abort", -1);

    for (int t = 0; t < 3; t++) begin
      random_roots_sig($urandom_range(1, 8));
      run($sformatf("rnd%0d", t), -1);
    end

    for (int k = 0; k < 8; k++) sig[k] = 8'($urandom);
    run("rawrnd", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
